// File: rtl/div_pkg.sv
// Shared types and constants for the signed 64/32 divider sequencer.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

    // A 33-bit signed quotient fits in 32 bits only if its top two bits agree.
    function automatic logic quo_ovf(input logic [32:0] q);
        return q[32] ^ q[31];
    endfunction

endpackage

// File: rtl/div_seq_ctrl_cnt.sv
// Wait-cycle counter for the divider sequencer: clear, count, terminal flag.
module div_timeout_cnt #(
    parameter int CNT_W          = 6,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/div_seq_ctrl.sv
// Request/result sequencer around the iterative signed 64/32 divider:
// screens divide-by-zero, starts the divider, checks overflow and timeout.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_quo,
    output logic [31:0]      out_rem,
    output logic [1:0]       out_err,
    output logic [TAG_W-1:0] out_tag,
    output logic [63:0]      div_a,
    output logic [31:0]      div_b,
    output logic             div_start,
    input  logic [32:0]      div_quo,
    input  logic [31:0]      div_rem,
    input  logic             div_finish,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [63:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      rem_q, rem_d;
    logic [1:0]       err_q, err_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    div_timeout_cnt #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    tag_d = in_tag;
                    if (in_b == 32'd0) begin
                        quo_d   = DIV0_QUO;
                        rem_d   = in_a[31:0];
                        err_d   = ERR_DIV0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_clr = 1'b1;
                state_d = S_SETTLE;
            end
            // Finish may still be high from the previous operation here.
            S_SETTLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_en = 1'b1;
                if (div_finish) begin
                    quo_d   = div_quo[31:0];
                    rem_d   = div_rem;
                    err_d   = quo_ovf(div_quo) ? ERR_OVF : ERR_OK;
                    state_d = S_DONE;
                end else if (cnt_tc) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    err_d   = ERR_TMO;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign div_start = (state_q == S_START);
    assign busy      = (state_q != S_IDLE);

    assign div_a   = a_q;
    assign div_b   = b_q;
    assign out_quo = quo_q;
    assign out_rem = rem_q;
    assign out_err = err_q;
    assign out_tag = tag_q;

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Sequencing front/back end for the signed 64/32 iterative divider. Accepts a dividend/divisor request over valid/ready and screens divide-by-zero without starting the divider. Otherwise it holds the operands stable, pulses the divider's start input and waits for its finish flag. It then checks the 33-bit quotient for 32-bit overflow and presents a registered result (quo, rem, error code, tag) over valid/ready to the writeback stage.

Parameters:
TAG_W, 4, width of the request tag carried through to the result
TIMEOUT_CYCLES, 40, max cycles in WAIT before a timeout error (divider nominal latency ~33)
CNT_W, 6, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_a  in  64  signed dividend
in_b  in  32  signed divisor
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_quo  out  32  signed quotient, truncated toward zero
out_rem  out  32  signed remainder, sign follows dividend
out_err  out  2  00 ok, 01 div-by-zero, 10 overflow, 11 timeout
out_tag  out  TAG_W  tag of the result
div_a  out  64  registered dividend to divider
div_b  out  32  registered divisor to divider
div_start  out  1  drives divider start input (its rst pin), one-cycle pulse
div_quo  in  33  divider quotient
div_rem  in  32  divider remainder
div_finish  in  1  divider done flag (level)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE; in_ready 1 (combinational from IDLE); out_valid 0; div_start 0; out_quo/out_rem/out_err/out_tag/div_a/div_b all 0; counter 0.
- States: IDLE, START, SETTLE, WAIT, DONE.
- IDLE: in_ready=1. On accept, latch a, b and tag.
  - in_b==0: go directly to DONE with out_quo=32'hFFFFFFFF, out_rem=in_a[31:0], out_err=01. Divider is never started.
  - Otherwise: go to START.
- START: div_start=1 for exactly this cycle; counter cleared. Next state is SETTLE.
- SETTLE: one cycle in which div_finish is ignored, so a stale finish from the previous operation is masked. Next state is WAIT.
- WAIT: counter increments each cycle.
  - On div_finish=1: capture out_quo=div_quo[31:0] and out_rem=div_rem. out_err=10 if div_quo[32]!=div_quo[31], else 00. Go to DONE.
  - Else, if counter reaches TIMEOUT_CYCLES-1: out_quo=0, out_rem=0, out_err=11. Go to DONE.
  - If finish and timeout occur in the same cycle, finish wins.
- DONE: out_valid=1. Outputs are held stable while out_ready=0. On out_valid & out_ready, go to IDLE. A new request cannot be accepted in the same cycle because in_ready is low in DONE.
- div_a and div_b change only on accept, and stay stable from START through DONE.
- Latency, nonzero divisor: accept at cycle 0, div_start at 1, SETTLE at 2, WAIT from 3. out_valid rises the cycle after finish is seen.
- Latency, zero divisor: out_valid is high on the cycle after accept.
- rst in any state, including mid-WAIT: go to IDLE, clear out_valid, drop div_start. A finish from the abandoned operation arriving later is ignored, because only START→SETTLE→WAIT samples it.
- Overflow case: remainder is still reported as-is, out_quo is the truncated low 32 bits.

Decomposition:
- Shared package div_pkg: state encoding constants; error codes ERR_OK, ERR_DIV0, ERR_OVF, ERR_TMO; DIV0_QUO constant 32'hFFFFFFFF.
- One sub-module, div_timeout_cnt: clear, enable, terminal-count output, parameterised by CNT_W and TIMEOUT_CYCLES.
- The FSM and output registers stay in div_seq_ctrl.

Test Plan:
- a=100, b=7, divider model finishing after 33 cycles -> one div_start pulse; out_quo=14, out_rem=2, err=00, tag echoed.
- a=-100, b=7 -> out_quo=32'hFFFFFFF2, out_rem=32'hFFFFFFFE, err=00. Also a=100, b=-7 -> out_quo=-14, out_rem=2.
- b=0, a=64'h1234 -> div_start never asserted; out_valid on cycle 1; out_quo=FFFFFFFF, out_rem=00001234, err=01.
- a=2^40, b=1, model returns quo[32]!=quo[31] -> err=10. Also: model never finishes -> err=11 exactly TIMEOUT_CYCLES cycles after WAIT entry.
- out_ready held low 5 cycles in DONE -> outputs, out_valid and in_ready=0 held stable; on out_ready=1, return to IDLE next cycle; back-to-back requests both complete in order.
- rst asserted mid-WAIT, then stale div_finish pulse, then new request a=9, b=2 -> stale finish ignored; result quo=4, rem=1, err=00.
